// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with hold-until-release grants.
// A winner is picked only from IDLE, starting the search at the rotating
// pointer. The grant is held until the holder signals done, drops its
// request, or exhausts the optional hold budget. Every grant is followed by
// at least one all-zero cycle so the one-hot selects downstream never overlap.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);
  localparam bit LIMIT_ON = (HOLD_MAX != 0);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          to_q, to_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]    win;
  logic          rel_user;
  logic          rel_lim;

  // First requester found scanning ptr, ptr+1, ... with 3-bit wrap.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] r);
    logic [2:0] pick;
    logic [2:0] cand;
    logic       hit;
    pick = ptr;
    hit  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!hit && r[cand]) begin
        pick = cand;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  // Next-state logic: arbitration in IDLE, release decision in GRANT.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    vld_d    = vld_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    to_d     = 1'b0;
    win      = rr_pick(ptr_q, req);
    rel_user = done | ~req[idx_q];
    rel_lim  = LIMIT_ON && (cnt_q == CNT_MAX);
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          idx_d   = win;
          gnt_d   = 8'h01 << win;
          vld_d   = 1'b1;
          cnt_d   = CW'(1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (rel_user || rel_lim) begin
          // A voluntary release outranks the limit, so the flag only marks
          // releases forced purely by the hold budget.
          gnt_d   = 8'h00;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 3'd1;
          to_d    = ~rel_user;
          state_d = S_IDLE;
        end else if (LIMIT_ON && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_rr_arbiter_8;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  bit m_busy = 1'b0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_ten  = 0;
  bit m_to   = 1'b0;

  rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int m_pick(input int p, input logic [7:0] r);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return 0;
  endfunction

  // Model: who holds the resource, for how many cycles, and where the search starts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_idx  <= 0;
      m_ptr  <= 0;
      m_ten  <= 0;
      m_to   <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_busy) begin
        if (req != 8'h00) begin
          m_idx  <= m_pick(m_ptr, req);
          m_busy <= 1'b1;
          m_ten  <= 1;
        end
      end else if (done || !req[m_idx] || (HOLD != 0 && m_ten >= HOLD)) begin
        m_busy <= 1'b0;
        m_ptr  <= (m_idx + 1) % 8;
        m_to   <= !(done || !req[m_idx]);
      end else begin
        m_ten <= m_ten + 1;
      end
    end
  end

  // Compare DUT outputs to the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("cyc_gnt", gnt, m_busy ? (32'h1 << m_idx) : 32'h0);
      chk("cyc_idx", gnt_idx, m_idx);
      chk("cyc_valid", gnt_valid, m_busy);
      chk("cyc_timeout", timeout, m_to);
    end
  end

  initial begin
    int ng;
    int held;
    #3 rst_n = 1'b0;
    #4;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_idx", gnt_idx, 3'd0);
    chk("rst_valid", gnt_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Single requester, then done
    req = 8'h04;
    cyc(1);
    chk("single_gnt", gnt, 8'h04);
    chk("single_idx", gnt_idx, 3'd2);
    chk("single_valid", gnt_valid, 1'b1);
    done = 1'b1;
    cyc(1);
    chk("single_rel", gnt, 8'h00);
    chk("single_keep_idx", gnt_idx, 3'd2);
    chk("model_ptr", m_ptr, 3);
    done = 1'b0;
    req  = 8'h00;
    cyc(1);

    // Round-robin order from ptr=0
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    req   = 8'hFF;
    done  = 1'b1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 9; i++) begin
      cyc(1);
      if (gnt_valid) begin
        chk("rr_order", gnt_idx, ng % 8);
        ng++;
      end
    end
    chk("rr_count", ng, 9);
    done = 1'b0;
    req  = 8'h00;
    cyc(2);

    // Pointer skip and wrap: grant 5 then drop, leaving ptr=6
    req = 8'h20;
    cyc(1);
    chk("skip_pre_idx", gnt_idx, 3'd5);
    req = 8'h00;
    cyc(1);
    chk("skip_pre_rel", gnt, 8'h00);
    req = 8'h03;
    cyc(1);
    chk("wrap_idx", gnt_idx, 3'd0);
    chk("wrap_gnt", gnt, 8'h01);
    done = 1'b1;
    cyc(1);
    chk("wrap_rel", gnt, 8'h00);
    done = 1'b0;
    cyc(1);
    chk("ptr1_idx", gnt_idx, 3'd1);
    chk("ptr1_gnt", gnt, 8'h02);
    req = 8'h00;
    cyc(2);

    // Timeout with HOLD_MAX=4
    req = 8'h80;
    cyc(1);
    held = 0;
    for (int i = 0; i < 10 && gnt == 8'h80; i++) begin
      held++;
      cyc(1);
    end
    chk("to_held", held, 4);
    chk("to_pulse", timeout, 1'b1);
    chk("to_gnt_low", gnt, 8'h00);
    cyc(1);
    chk("to_regnt", gnt, 8'h80);
    chk("to_pulse_end", timeout, 1'b0);
    req = 8'h00;
    cyc(2);

    // Withdraw and ignored requests
    req = 8'h08;
    cyc(1);
    chk("wd_gnt3", gnt, 8'h08);
    req = 8'h28;
    cyc(1);
    chk("wd_ignore5", gnt, 8'h08);
    req = 8'h20;
    cyc(1);
    chk("wd_rel", gnt, 8'h00);
    chk("wd_no_timeout", timeout, 1'b0);
    cyc(1);
    chk("wd_next5", gnt_idx, 3'd5);
    chk("wd_next5_gnt", gnt, 8'h20);
    req = 8'h00;
    cyc(2);

    // Asynchronous reset mid-grant
    req = 8'h10;
    cyc(1);
    chk("ar_gnt", gnt, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt_clr", gnt, 8'h00);
    chk("ar_valid_clr", gnt_valid, 1'b0);
    @(negedge clk);
    req   = 8'h11;
    rst_n = 1'b1;
    cyc(1);
    chk("ar_regnt_idx", gnt_idx, 3'd0);
    chk("ar_regnt_gnt", gnt, 8'h01);
    req = 8'h00;
    cyc(2);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = 8'h00;
          1:       req = r[7:0] & r[15:8];
          2:       req = 8'h01 << r[18:16];
          default: req = r[7:0];
        endcase
      end
      done = ($urandom_range(0, 4) == 0);
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares one downstream resource among eight requesters. It selects a single requester, holds the grant until release, and reports the winner two ways: as a 3-bit binary index and as the one-hot 3-to-8 decode of that index. It sits in front of decoder-selected datapaths, where the one-hot `gnt` drives the per-slot enables directly.

## Interface
- `HOLD_MAX`, default 16: maximum cycles one grant may be held before it is forcibly released. 0 disables the timeout. Counter width is `$clog2(HOLD_MAX+1)`, minimum 1.
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `req`  input  8  request vector; bit i is requester i; level-sensitive
- `done`  input  1  the current grant holder releases the resource; sampled only while in GRANT
- `gnt`  output  8  one-hot grant; all-zero when no grant is active
- `gnt_idx`  output  3  binary index of the current or last grantee
- `gnt_valid`  output  1  a grant is active; equals `|gnt`
- `timeout`  output  1  one-cycle pulse marking a forced release

## Operation
- All outputs and state are registered.
- On reset (`rst_n`=0, asynchronous):
  - state=IDLE, `gnt`=8'h00, `gnt_idx`=3'd0, `gnt_valid`=0, `timeout`=0
  - priority pointer `ptr`=3'd0, hold counter=0
- **IDLE state**
  - If `req`==0: stay in IDLE.
  - Otherwise the winner is the first set bit scanning `ptr`, `ptr`+1, … `ptr`+7, all mod 8.
  - At the edge: `gnt_idx`←winner, `gnt`←1<<winner, `gnt_valid`←1, counter←1, state←GRANT.
- **GRANT state**: release occurs when any of the following holds at the edge:
  - `done`=1
  - `req[gnt_idx]`=0 (requester withdrew)
  - `HOLD_MAX`≠0 and counter==`HOLD_MAX`
- **On release**
  - `gnt`←0, `gnt_valid`←0, `ptr`←`gnt_idx`+1 (3-bit wrap, so 7→0), state←IDLE.
  - `gnt_idx` keeps the last grantee.
- **Timeout flag**
  - `timeout`←1 for exactly one cycle only when the release was caused solely by the counter limit, i.e. `done`=1 or a withdrawn request takes precedence and gives `timeout`=0.
  - `timeout`←0 in every other cycle.
- **No release**: the counter increments, saturating at `HOLD_MAX`. With `HOLD_MAX`=0 the counter is not used.
- Changes to `req` bits other than the holder's have no effect during GRANT. The decision is re-evaluated only in IDLE.
- `done` asserted in IDLE is ignored.

## Timing
- Request-to-grant latency: `req` set before edge N gives `gnt` high after edge N (1 cycle).
- Grant tenure: a minimum of 1 cycle; with `HOLD_MAX`=H, a maximum of H cycles of `gnt` high.
- Release latency: `done` sampled at edge M gives `gnt` low after edge M.
- There is always at least one IDLE cycle with `gnt`=0 between consecutive grants, including the same requester re-winning. This guarantees a glitch-free handover in the downstream one-hot selects.
- Fairness: with all eight requesting continuously, each requester is granted exactly once per 8 grants, in order ptr, ptr+1, ….
- Reset mid-GRANT: outputs clear immediately (asynchronously); `ptr` returns to 0.
- Simultaneous `done` and counter==`HOLD_MAX`: this is a normal release with `timeout`=0.

## Test plan
- **Reset, then single requester**: `req`=8'h04 → next edge `gnt`=8'h04, `gnt_idx`=2, `gnt_valid`=1. Pulse `done` → `gnt`=0 after that edge, `ptr`=3.
- **Round-robin order**: `req`=8'hFF held, `done` pulsed on every GRANT cycle → grant sequence 0,1,2,…,7,0 with one idle cycle between each; each `gnt` exactly one-hot.
- **Pointer skip and wrap**: `ptr`=6, `req`=8'b0000_0011 → grant 0. Then with `ptr`=1 and `req` still 8'h03 → grant 1.
- **Timeout**: `HOLD_MAX`=4, `req`=8'h80 held, `done`=0 → `gnt`=8'h80 for 4 cycles, then `gnt`=0 with `timeout`=1 for one cycle; re-grant to 7 after one idle cycle.
- **Withdraw and ignored requests**: holder 3 granted, `req[5]` raised mid-grant → no change. Then drop `req[3]` → release, `timeout`=0, next grant is 5.
- **Async reset mid-grant**: drop `rst_n` between edges while `gnt`=8'h10 → `gnt`=0, `gnt_valid`=0 immediately. After reset is released with `req`=8'h11 → grant 0.
